// File: rtl/rptr_empty_ctrl.sv
// ----------------------------------------------------------------------------
// rptr_empty_ctrl
//   Read-domain pointer and empty-flag controller for the dual-clock FIFO.
//   Keeps the binary read pointer and drives the RAM read address from it.
//   Publishes the registered Gray read pointer so sync_r2w can carry it into
//   the write domain. Compares the synchronized Gray write pointer with the
//   next read pointer to produce registered empty / almost-empty flags, a
//   read-side fill level and a sticky underflow error.
//
// Parameters
//   ASIZE          RAM address width; depth = 2**ASIZE, pointers ASIZE+1 bits
//   AEMPTY_THRESH  raempty asserts when the fill level is <= this value
//
// Ports
//   rclk        in   read-domain clock (posedge)
//   rrst        in   synchronous active-high reset
//   rinc        in   read request, accepted only while rempty==0
//   rq2_wptr    in   Gray write pointer, already synchronized into rclk
//   uflow_clr   in   clears runderflow (wins over a new underflow)
//   raddr       out  binary RAM read address (head entry)
//   rptr        out  registered Gray read pointer
//   rempty      out  FIFO empty as seen from the read domain
//   raempty     out  fill level <= AEMPTY_THRESH
//   rlevel      out  entries available to read, 0 .. 2**ASIZE
//   runderflow  out  sticky: rinc seen while empty
// ----------------------------------------------------------------------------
module rptr_empty_ctrl #(
    parameter int unsigned ASIZE         = 4,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic             uflow_clr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam logic [ASIZE:0] AE_LIM = (ASIZE+1)'(AEMPTY_THRESH);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbin_nxt;
    logic [ASIZE:0] rgray_nxt;
    logic [ASIZE:0] wbin_s;
    logic [ASIZE:0] level_nxt;
    logic           rd_en;

    // rempty is a registered flag, so a read on the edge that drains the
    // FIFO already sees rempty=1 on the following cycle; nothing slips past.
    assign rd_en = rinc & ~rempty;

    assign rbin_nxt  = rbin + (ASIZE+1)'(rd_en);
    assign rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above its position.
    always_comb begin
        wbin_s = '0;
        for (int unsigned i = 0; i <= ASIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    assign level_nxt = wbin_s - rbin_nxt;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbin_nxt;
            rptr    <= rgray_nxt;
            rempty  <= (rgray_nxt == rq2_wptr);
            rlevel  <= level_nxt;
            raempty <= (level_nxt <= AE_LIM);
            if (uflow_clr) begin
                runderflow <= 1'b0;
            end else if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

    assign raddr = rbin[ASIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rptr_empty_ctrl
//   Directed bench for rptr_empty_ctrl (ASIZE=4, AEMPTY_THRESH=2).
//   A counting model (read count, write count, level = difference mod 32)
//   predicts every output; it is compared against the DUT on each negedge.
//   Literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_rptr_empty_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic       uflow_clr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    int n_vec = 0;
    int n_err = 0;

    // write count currently presented by the (already synchronized) writer
    int wcnt = 0;

    rptr_empty_ctrl #(.ASIZE(4), .AEMPTY_THRESH(2)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .uflow_clr  (uflow_clr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    always_comb rq2_wptr = to_gray(wcnt);

    // ---------------- behavioural model ----------------
    int  m_rcnt  = 0;
    int  m_level = 0;
    bit  m_empty = 1'b1;
    bit  m_ae    = 1'b1;
    bit  m_uf    = 1'b0;
    bit  m_valid = 1'b0;
    bit  m_was_rst = 1'b1;

    always @(posedge rclk) begin
        bit acc;
        if (rrst) begin
            m_valid   = 1'b1;
            m_was_rst = 1'b1;
            m_rcnt    = 0;
            m_level   = 0;
            m_empty   = 1'b1;
            m_ae      = 1'b1;
            m_uf      = 1'b0;
        end else if (m_valid) begin
            m_was_rst = 1'b0;
            acc = rinc && !m_empty;
            if (uflow_clr)            m_uf = 1'b0;
            else if (rinc && m_empty) m_uf = 1'b1;
            m_rcnt  = (m_rcnt + int'(acc)) % 32;
            m_level = (((wcnt % 32) - m_rcnt) % 32 + 32) % 32;
            m_empty = (m_level == 0);
            m_ae    = (m_level <= 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0] prev_rptr = '0;

    always @(negedge rclk) begin
        if (m_valid) begin
            n_vec++;
            if (raddr !== 4'(m_rcnt % 16) || rptr !== to_gray(m_rcnt) ||
                rempty !== m_empty || raempty !== m_ae ||
                rlevel !== 5'(m_level) || runderflow !== m_uf) begin
                n_err++;
                $display("FAIL model t=%0t: got raddr=%0d rptr=%b empty=%b aempty=%b level=%0d uf=%b, expected raddr=%0d rptr=%b empty=%b aempty=%b level=%0d uf=%b",
                         $time, raddr, rptr, rempty, raempty, rlevel, runderflow,
                         m_rcnt % 16, to_gray(m_rcnt), m_empty, m_ae, m_level, m_uf);
            end
            if (!m_was_rst) begin
                n_vec++;
                if ($countones(prev_rptr ^ rptr) > 1) begin
                    n_err++;
                    $display("FAIL gray_step t=%0t: got %b -> %b, expected at most one bit change",
                             $time, prev_rptr, rptr);
                end
            end
            prev_rptr <= rptr;
        end
    end

    // ---------------- literal checks ----------------
    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge rclk);
    endtask

    initial begin
        rrst = 1'b1; rinc = 1'b1; uflow_clr = 1'b0; wcnt = 0;

        // 1. reset with rinc held high
        tick(); tick();
        lit("rst_rempty",  int'(rempty), 1);
        lit("rst_raempty", int'(raempty), 1);
        lit("rst_rptr",    int'(rptr), 0);
        lit("rst_raddr",   int'(raddr), 0);
        lit("rst_rlevel",  int'(rlevel), 0);
        lit("rst_uflow",   int'(runderflow), 0);
        rrst = 1'b0; rinc = 1'b0;

        // 2. three entries visible, then drain
        wcnt = 3; tick();
        lit("fill_rempty",  int'(rempty), 0);
        lit("fill_rlevel",  int'(rlevel), 3);
        lit("fill_raempty", int'(raempty), 0);
        lit("fill_raddr",   int'(raddr), 0);
        rinc = 1'b1; tick();
        lit("rd1_raddr",   int'(raddr), 1);
        lit("rd1_rlevel",  int'(rlevel), 2);
        lit("rd1_raempty", int'(raempty), 1);
        tick();
        lit("rd2_raddr",   int'(raddr), 2);
        lit("rd2_rlevel",  int'(rlevel), 1);
        lit("rd2_raempty", int'(raempty), 1);
        tick();
        lit("rd3_rempty", int'(rempty), 1);
        lit("rd3_rptr",   int'(rptr), 5'b00010);

        // 3. underflow, held, then cleared with rinc still high
        tick();
        lit("uf_set",   int'(runderflow), 1);
        lit("uf_rptr",  int'(rptr), 5'b00010);
        tick();
        lit("uf_held",  int'(runderflow), 1);
        uflow_clr = 1'b1; tick();
        lit("uf_clr",   int'(runderflow), 0);
        uflow_clr = 1'b0; rinc = 1'b0;

        // 4. full level, then 32 reads with writes keeping pace
        rrst = 1'b1; wcnt = 0; tick();
        rrst = 1'b0; wcnt = 16; tick();
        lit("full_rlevel", int'(rlevel), 16);
        lit("full_rempty", int'(rempty), 0);
        rinc = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wcnt = (wcnt + 1) % 32;
            tick();
            if (k == 16) lit("wrap_mid_rptr", int'(rptr), 5'b11000);
            if (k == 31) lit("wrap_31_rptr",  int'(rptr), 5'b10000);
        end
        lit("wrap_0_rptr",  int'(rptr), 0);
        lit("wrap_0_raddr", int'(raddr), 0);
        lit("wrap_rlevel",  int'(rlevel), 16);
        for (int k = 0; k < 16; k++) tick();
        lit("drain_rempty", int'(rempty), 1);
        lit("drain_rlevel", int'(rlevel), 0);
        rinc = 1'b0;

        // 5. simultaneous read and write-pointer advance at level 1
        wcnt = 17; tick();
        lit("sim_pre_rlevel", int'(rlevel), 1);
        rinc = 1'b1; wcnt = 18; tick();
        lit("sim_rempty", int'(rempty), 0);
        lit("sim_rlevel", int'(rlevel), 1);
        rinc = 1'b0;

        // 6. reset mid-operation at level 5 with rinc high
        wcnt = 22; tick();
        lit("mid_rlevel", int'(rlevel), 5);
        rrst = 1'b1; rinc = 1'b1; wcnt = 0; tick();
        lit("mid_rst_rempty",  int'(rempty), 1);
        lit("mid_rst_raempty", int'(raempty), 1);
        lit("mid_rst_rptr",    int'(rptr), 0);
        lit("mid_rst_raddr",   int'(raddr), 0);
        lit("mid_rst_rlevel",  int'(rlevel), 0);
        lit("mid_rst_uflow",   int'(runderflow), 0);
        rrst = 1'b0; rinc = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
